module_teclado_scan: RTL and testbench

//  Scans a 4x4 matrix keypad and delivers one debounced key code per press, the

---
 rtl/module_teclado_scan.sv | 146 ++++++++++++++
 tb/tb_module_teclado_scan.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/module_teclado_scan.sv
// rtl/module_teclado_scan.sv - 4x4 keypad scanner with press/release debounce
// One column driven low per scan tick; emits one code and a 1-cycle valid per accepted press.
module module_teclado_scan #(
    parameter int COUNT_SCAN     = 10_000,
    parameter int BITS_SCAN      = 14,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int BITS_DEB       = 3
) (
    input  logic       clk_10Mhz_i,
    input  logic       reset_i,
    input  logic [3:0] fila_i,
    output logic [3:0] columna_o,
    output logic [3:0] tecla_o,
    output logic       tecla_valid_o,
    output logic       tecla_pressed_o
);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]           fila_s1_q, fila_s2_q;
    logic [BITS_SCAN-1:0] cnt_q, cnt_d;
    logic [1:0]           state_q, state_d;
    logic [1:0]           col_idx_q, col_idx_d;
    logic [1:0]           row_idx_q, row_idx_d;
    logic [BITS_DEB-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]           columna_q, columna_d;
    logic [3:0]           tecla_q, tecla_d;
    logic                 valid_q, valid_d;
    logic                 pressed_q, pressed_d;

    logic                 tick;
    logic                 any_low;
    logic                 row_low;
    logic [1:0]           row_first;
    logic [BITS_DEB-1:0]  deb_inc;
    logic                 deb_done;

    assign tick     = (cnt_q == BITS_SCAN'(COUNT_SCAN - 1));
    assign any_low  = (fila_s2_q != 4'hF);
    assign row_low  = ~fila_s2_q[row_idx_q];
    assign deb_inc  = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + 1'b1;
    assign deb_done = (deb_inc == BITS_DEB'(DEBOUNCE_SCANS));

    // Lowest-numbered active row wins when several are low together.
    always_comb begin
        row_first = 2'd3;
        if (!fila_s2_q[2]) row_first = 2'd2;
        if (!fila_s2_q[1]) row_first = 2'd1;
        if (!fila_s2_q[0]) row_first = 2'd0;
    end

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        deb_cnt_d = deb_cnt_q;
        tecla_d   = tecla_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        row_idx_d = row_first;
                        deb_cnt_d = BITS_DEB'(1);
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_low) begin
                        deb_cnt_d = deb_inc;
                        if (deb_done) begin
                            tecla_d   = {row_idx_q, col_idx_q};
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = ST_HELD;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!row_low) begin
                        deb_cnt_d = BITS_DEB'(1);
                        state_d   = ST_RELEASE;
                    end
                end
                default: begin
                    if (!row_low) begin
                        deb_cnt_d = deb_inc;
                        if (deb_done) begin
                            pressed_d = 1'b0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = ST_HELD;
                    end
                end
            endcase
        end
        columna_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk_10Mhz_i or negedge reset_i) begin
        if (!reset_i) begin
            fila_s1_q <= 4'hF;
            fila_s2_q <= 4'hF;
            cnt_q     <= '0;
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            deb_cnt_q <= '0;
            columna_q <= 4'b1110;
            tecla_q   <= 4'h0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            fila_s1_q <= fila_i;
            fila_s2_q <= fila_s1_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            deb_cnt_q <= deb_cnt_d;
            columna_q <= columna_d;
            tecla_q   <= tecla_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    assign columna_o       = columna_q;
    assign tecla_o         = tecla_q;
    assign tecla_valid_o   = valid_q;
    assign tecla_pressed_o = pressed_q;

endmodule

// File: tb/tb_module_teclado_scan.sv
// tb/tb_module_teclado_scan.sv - directed vector bench for module_teclado_scan
module tb_module_teclado_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fila;
    logic [3:0]  columna;
    logic [3:0]  tecla;
    logic        valid;
    logic        pressed;
    logic [15:0] keys;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    module_teclado_scan #(
        .COUNT_SCAN    (8),
        .BITS_SCAN     (3),
        .DEBOUNCE_SCANS(4),
        .BITS_DEB      (3)
    ) dut (
        .clk_10Mhz_i    (clk),
        .reset_i        (rst_n),
        .fila_i         (fila),
        .columna_o      (columna),
        .tecla_o        (tecla),
        .tecla_valid_o  (valid),
        .tecla_pressed_o(pressed)
    );

    // Key bit r*4+c pulls row r low while column c is driven low.
    always_comb begin
        fila = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !columna[c]) fila[r] = 1'b0;
    end

    typedef struct {
        logic [15:0] keys;
        int          cycles;
        int          exp_pulses;
        logic [3:0]  exp_tecla;
        logic        exp_pressed;
        logic [3:0]  exp_col;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) pulses++;
        end
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_col"},     int'(columna), 4'b1110);
        chk({tag, "_tecla"},   int'(tecla),   0);
        chk({tag, "_valid"},   int'(valid),   0);
        chk({tag, "_pressed"}, int'(pressed), 0);
        keys = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
    endtask

    initial begin
        // keys, cycles, pulses, tecla, pressed, columna
        vecs[0]  = '{16'h0000,   7, 0, 4'h0, 1'b0, 4'b1110};
        vecs[1]  = '{16'h0000,   1, 0, 4'h0, 1'b0, 4'b1101};
        vecs[2]  = '{16'h0000,   8, 0, 4'h0, 1'b0, 4'b1011};
        vecs[3]  = '{16'h0000,   8, 0, 4'h0, 1'b0, 4'b0111};
        vecs[4]  = '{16'h0000,   8, 0, 4'h0, 1'b0, 4'b1110};
        vecs[5]  = '{16'h0200,  39, 0, 4'h0, 1'b0, 4'b1101};
        vecs[6]  = '{16'h0200,   1, 1, 4'h9, 1'b1, 4'b1101};
        vecs[7]  = '{16'h0200, 360, 0, 4'h9, 1'b1, 4'b1101};
        vecs[8]  = '{16'h0000,  24, 0, 4'h9, 1'b1, 4'b1101};
        vecs[9]  = '{16'h0000,   8, 0, 4'h9, 1'b0, 4'b1011};
        vecs[10] = '{16'h0008,  24, 0, 4'h9, 1'b0, 4'b0111};
        vecs[11] = '{16'h0000,   8, 0, 4'h9, 1'b0, 4'b1110};
        vecs[12] = '{16'h4040,  48, 1, 4'h6, 1'b1, 4'b1011};
        vecs[13] = '{16'h0000,  16, 0, 4'h6, 1'b1, 4'b1011};
        vecs[14] = '{16'h0040,  16, 0, 4'h6, 1'b1, 4'b1011};
        vecs[15] = '{16'h0000,  32, 0, 4'h6, 1'b0, 4'b0111};

        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_col",     int'(columna), 4'b1110);
        chk("reset_tecla",   int'(tecla),   0);
        chk("reset_valid",   int'(valid),   0);
        chk("reset_pressed", int'(pressed), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            keys   = vecs[v].keys;
            pulses = 0;
            run(vecs[v].cycles);
            chk($sformatf("v%0d_pulses", v),  pulses,               vecs[v].exp_pulses);
            chk($sformatf("v%0d_tecla", v),   int'(tecla),          int'(vecs[v].exp_tecla));
            chk($sformatf("v%0d_pressed", v), int'(pressed),        int'(vecs[v].exp_pressed));
            chk($sformatf("v%0d_col", v),     int'(columna),        int'(vecs[v].exp_col));
        end

        // Reset in the middle of debouncing row2/col1.
        keys   = 16'h0200;
        pulses = 0;
        run(36);
        chk("mid_deb_pressed", int'(pressed), 0);
        chk("mid_deb_pulses",  pulses,        0);
        async_reset_check("rst_deb");
        run(4);
        chk("rst_deb_restart_col", int'(columna), 4'b1110);
        run(36);
        chk("rst_deb_pulses",  pulses,        0);
        chk("rst_deb_tecla",   int'(tecla),   0);
        chk("rst_deb_pressed", int'(pressed), 0);

        // Reset while a key is held.
        keys   = 16'h0200;
        pulses = 0;
        begin
            int budget;
            budget = 200;
            while (!pressed && budget > 0) begin
                run(1);
                budget--;
            end
            chk("held_wait_timeout", int'(budget > 0), 1);
        end
        run(20);
        chk("held_pulses",  pulses,        1);
        chk("held_tecla",   int'(tecla),   4'h9);
        chk("held_pressed", int'(pressed), 1);
        async_reset_check("rst_held");
        run(4);
        chk("rst_held_restart_col", int'(columna), 4'b1110);
        run(40);
        chk("rst_held_pulses",  pulses,        0);
        chk("rst_held_tecla",   int'(tecla),   0);
        chk("rst_held_pressed", int'(pressed), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
